// File: rtl/lsu_pkg.sv
// Shared width codes, response error codes, FSM states and request legality check
// for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_t;

  // Illegal encodings take priority over misalignment.
  function automatic logic [1:0] req_check(input logic we, input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (we && funct3[2]);
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    if (illegal)         return ERR_ILLEGAL;
    else if (misaligned) return ERR_MISALIGN;
    else                 return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store-data lane replication and load lane select/extension.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'd0;
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      F3_H, F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      F3_W: begin
        be        = 4'b1111;
        rdata_ext = rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory transaction per accepted request, 2 cycles min
// latency (1 on error); req_ready only in IDLE, mem_req held until ack or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt;
  logic [1:0]  chk_err;
  logic [3:0]  be_dec;
  logic [31:0] rdata_ext;

  assign chk_err = req_check(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be_dec),
    .wdata_rep (mem_wdata),
    .rdata_ext (rdata_ext)
  );

  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_we   = mem_req & we_q;
  assign mem_be   = mem_req ? be_dec : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (chk_err == ERR_OK) ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        mem_req = 1'b1;
        if (mem_ack || (cnt == CNT_LAST)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cnt        <= 8'd0;
      resp_rdata <= 32'd0;
      resp_err   <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 8'd0;
            if (chk_err != ERR_OK) begin
              resp_err   <= chk_err;
              resp_rdata <= 32'd0;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            resp_err   <= ERR_OK;
            resp_rdata <= we_q ? 32'd0 : rdata_ext;
          end else if (cnt == CNT_LAST) begin
            resp_err   <= ERR_TIMEOUT;
            resp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed checks of load_store_unit against a byte-level reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  int          n_checks = 0;
  int          n_errors = 0;

  int          mem_waits = 0;
  logic [31:0] mem_rdata_val = 32'd0;
  int          mcnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after mem_waits wait cycles, otherwise drives noise.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    mcnt      = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mcnt++;
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_be    = mem_be;
        cap_wdata = mem_wdata;
        if (mcnt == mem_waits + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_rdata_val;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        mcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int waits, output logic [31:0] got_rd);
    int          n, off, exp_lat, exp_reqs, lat, req_cyc;
    logic        illegal, misal, tout, got;
    logic [1:0]  exp_err;
    logic [7:0]  be8;
    logic [31:0] mask, v, exp_rd, exp_wd;
    logic [1:0]  r_err;

    case (f3[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      default: n = 4;
    endcase
    off     = int'(addr[1:0]);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    misal   = (off % n) != 0;
    tout    = waits >= TO;
    exp_err = illegal ? 2'b11 : misal ? 2'b01 : tout ? 2'b10 : 2'b00;
    be8     = 8'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
    v    = rdata >> (8 * off);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    exp_rd   = (exp_err == 2'b00 && !we) ? v : 32'd0;
    exp_lat  = (illegal || misal) ? 1 : tout ? TO + 1 : waits + 2;
    exp_reqs = (illegal || misal) ? 0 : tout ? TO : waits + 1;

    mem_waits     = waits;
    mem_rdata_val = rdata;
    cap_addr = 32'd0; cap_be = 4'd0; cap_wdata = 32'd0; cap_we = 1'b0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check_val("ready_idle", 32'(req_ready), 32'd1);

    got = 1'b0; lat = 0; req_cyc = 0; got_rd = 32'd0; r_err = 2'b00;
    for (int k = 1; k <= 64 && !got; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_req) req_cyc++;
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
        got_rd = resp_rdata;
        r_err  = resp_err;
        check_val("mreq_in_resp", 32'(mem_req), 32'd0);
      end
    end
    check_val("resp_seen", 32'(got), 32'd1);
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("req_cycles", 32'(req_cyc), 32'(exp_reqs));
    check_val("resp_err", 32'(r_err), 32'(exp_err));
    check_val("resp_rdata", got_rd, exp_rd);
    if (exp_reqs > 0) begin
      check_val("mem_addr", cap_addr, {addr[31:2], 2'b00});
      check_val("mem_be", 32'(cap_be), 32'(be8[3:0]));
      check_val("mem_we", 32'(cap_we), 32'(we));
      if (we) check_val("mem_wdata", cap_wdata, exp_wd);
    end
    @(negedge clk);
    check_val("resp_pulse", 32'(resp_valid), 32'd0);
    check_val("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] rdy_seen, rsp_seen, mreq_seen, rdy_exp, rsp_exp, mreq_exp;
    int          rsp_cnt;
    logic [2:0]  f3;
    int          waits;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    @(negedge clk); @(negedge clk);
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_mreq", 32'(mem_req), 32'd0);
    check_val("rst_mwe", 32'(mem_we), 32'd0);
    check_val("rst_maddr", mem_addr, 32'd0);
    check_val("rst_mbe", 32'(mem_be), 32'd0);
    check_val("rst_mwdata", mem_wdata, 32'd0);
    check_val("rst_rvalid", 32'(resp_valid), 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_rerr", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b1, F3_B, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, rd);
    check_val("sb_be", 32'(cap_be), 32'h8);
    check_val("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    do_access(1'b0, F3_H, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, rd);
    check_val("lh_spec", rd, 32'hFFFF_8001);
    do_access(1'b0, F3_HU, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, rd);
    check_val("lhu_spec", rd, 32'h0000_8001);
    do_access(1'b0, F3_W, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, rd);
    do_access(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h1234_5678, 0, rd);
    do_access(1'b1, F3_BU, 32'h0000_3001, 32'h55, 32'h0, 0, rd);
    do_access(1'b0, F3_W, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 100, rd);
    do_access(1'b0, F3_W, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, TO - 1, rd);
    check_val("ack_last_cycle", rd, 32'hDEAD_BEEF);

    // Reset in the middle of an ISSUE phase.
    mem_waits = 1000;
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("mid_mreq_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_mreq_async", 32'(mem_req), 32'd0);
    check_val("mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) rsp_cnt++;
    end
    check_val("mid_no_resp", 32'(rsp_cnt), 32'd0);
    do_access(1'b0, F3_B, 32'h0000_0102, 32'h0, 32'h0080_0000, 1, rd);

    // Back-to-back loads with req_valid held high.
    mem_waits = 0;
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      rdy_seen[k]  = req_ready;
      rsp_seen[k]  = resp_valid;
      mreq_seen[k] = mem_req;
      rdy_exp[k]   = (k % 3) == 0;
      rsp_exp[k]   = (k % 3) == 2;
      mreq_exp[k]  = (k % 3) == 1;
    end
    req_valid = 1'b0;
    check_val("b2b_ready", 32'(rdy_seen), 32'(rdy_exp));
    check_val("b2b_resp", 32'(rsp_seen), 32'(rsp_exp));
    check_val("b2b_mreq", 32'(mreq_seen), 32'(mreq_exp));
    @(negedge clk);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2))
                                          : int'($urandom_range(0, TO - 1));
      do_access(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, waits, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. Takes the effective address the ALU computes (base + offset) plus store data and a width/sign code, runs one data-memory transaction over a valid/ack handshake with wait states, and returns aligned, sign- or zero-extended load data to the writeback path. Handles misalignment and memory timeout as reported errors, not silent corruption.

## Interface

- TIMEOUT_CYCLES, 64: cycles `mem_req` may stay high without `mem_ack` before the access is aborted; must be ≥1 and fit in 8 bits.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (RV32I load/store width codes).
- req_addr  in  32  effective byte address (ALU `out`).
- req_wdata  in  32  store data (rs2), LSB-justified.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address: {req_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables, bit i = byte lane i.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word, valid when `mem_ack`=1.
- mem_ack  in  1  memory completion, single-cycle pulse.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.

## Operation

- FSM states: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE: `req_ready`=1. On `req_valid`: latch we, funct3, addr, wdata. Check: H/HU with addr[0]=1, or W with addr[1:0]≠0 → err 01; funct3 ∈ {011,110,111}, or store with 100/101 → err 11 (illegal wins over misaligned). Error → RESP without touching memory; else → ISSUE, counter cleared.
- ISSUE: `mem_req`=1; mem_we/addr/be/wdata constant from latched request. `mem_ack` → latch rdata, err 00, → RESP. Otherwise counter increments; at counter = TIMEOUT_CYCLES−1 without ack → err 10, → RESP. Ack in the timeout cycle counts as success.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `req_valid` ignored outside IDLE.
- Byte enables: B/BU → 0001<<addr[1:0]; H/HU → 0011<<addr[1]*2; W → 1111.
- Store data: B → {4{wdata[7:0]}}, H → {2{wdata[15:0]}}, W → wdata.
- Load extract: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough.
- `mem_ack` outside ISSUE is ignored.

## Timing

- Reset values: req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Accept at edge E0; `mem_req` high cycle after E0; ack in same cycle as first `mem_req` → `resp_valid` the following cycle. Minimum load/store latency: 2 cycles accept-to-response; error path: 1 cycle.
- Next request can be accepted in the cycle after `resp_valid` (back-to-back throughput 1 access / 3 cycles at zero wait).
- Timeout: `mem_req` high for exactly TIMEOUT_CYCLES cycles, then `resp_valid` with err 10; `mem_req` low in RESP.
- All outputs registered or decoded from registered state; no combinational path req_* → mem_* or mem_* → resp_*.
- `rst_n` low mid-transaction: `mem_req` drops immediately (asynchronously), transaction abandoned, no `resp_valid` issued.

## Structure

- Package `lsu_pkg`: funct3 width constants, resp_err codes, FSM state enum, default TIMEOUT_CYCLES.
- One sub-module `lsu_align`: purely combinational byte-enable/store-replication and load lane-select/extension; top holds FSM, request latch, timeout counter.

## Test plan

- Store B, addr 0x1003, wdata 0x000000A5, ack after 0 waits → mem_addr 0x1000, mem_be 1000, mem_wdata 0xA5A5A5A5, resp_err 00, resp_rdata 0, resp_valid 2 cycles after accept.
- Load H, addr 0x2002, rdata 0x8001_1234, ack after 3 waits → resp_rdata 0xFFFF8001; same with HU → 0x00008001.
- Load W, addr 0x3001 → no mem_req ever, resp_err 01 next cycle; funct3 011 → resp_err 11.
- Load W, no ack, TIMEOUT_CYCLES=4 → mem_req high exactly 4 cycles, resp_err 10; ack in 4th cycle instead → err 00.
- rst_n pulsed low during ISSUE → mem_req 0 same cycle, no resp_valid, req_ready 1, next access completes normally.
- Back-to-back loads with req_valid held high → accepts spaced 3 cycles, each resp_valid exactly one cycle.
